rst_seq_wdt: RTL

Synthesizable, parametrised reset sequencer and simulation-cycle watchdog for the processor testbench and top level. It takes one asynchronous active-low reset and produces NUM_CH synchronous active-high reset channels released in a staggered order (e.g. memories, then register file, then pipeline, then fetch). After release it counts run cycles and halts on an external error or when a cycle budget is exceeded, reporting which event occurred.

---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/rst_seq_wdt_sync.sv | 22 ++
 rtl/rst_seq_wdt.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer / run watchdog.
package rst_seq_pkg;

  // Sequencer / watchdog FSM states.
  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    HALT    = 2'd3
  } state_t;

  // Width of the release counter. It must hold the largest channel release
  // point, HOLD_CYC + (NUM_CH-1)*STAGGER.
  function automatic int rel_cnt_w(input int num_ch, input int hold_cyc,
                                   input int stagger);
    return $clog2(hold_cyc + (num_ch - 1) * stagger + 1);
  endfunction

endpackage

// File: rtl/rst_seq_wdt_sync.sv
// Two-flop reset synchronizer.
// Reset asserts asynchronously and deasserts synchronously to i_clk.
module rst_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_sync
);

  logic [1:0] r_sync;

  // Shift a 1 in after reset release; the output reads high after two edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], 1'b1};
    end
  end

  assign o_rst_sync = r_sync[1];

endmodule

// File: rtl/rst_seq_wdt.sv
// Reset sequencer and run-cycle watchdog.
// One async active-low reset in, NUM_CH active-high reset channels out.
// The channels are released in a staggered order. After the last release,
// run cycles are counted. The run halts on err or when the cycle budget is
// exceeded.
module rst_seq_wdt
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int HOLD_CYC = 2,
  parameter int STAGGER  = 1,
  parameter int TIMEOUT  = 100004,
  parameter int CNT_W    = 20,
  parameter int HALT_RST = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              err,
  output logic [NUM_CH-1:0] rst_out,
  output logic              done,
  output logic              halt,
  output logic              err_seen,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [1:0]        o_dbg_state
);

  localparam int REL_W = rel_cnt_w(NUM_CH, HOLD_CYC, STAGGER);

  logic              w_sync;
  logic [REL_W-1:0]  w_rel_nxt;
  logic [NUM_CH-1:0] w_rel_mask;
  logic              w_last;
  logic [CNT_W-1:0]  w_cyc_nxt;
  logic              w_tmo;

  state_t            r_state;
  logic [REL_W-1:0]  r_rel_cnt;
  logic [NUM_CH-1:0] r_rst_out;
  logic              r_done;
  logic              r_halt;
  logic              r_err_seen;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_cycle_count;

  rst_sync u_sync (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .o_rst_sync (w_sync)
  );

  assign w_rel_nxt = r_rel_cnt + 1'b1;
  assign w_cyc_nxt = r_cycle_count + 1'b1;
  assign w_tmo     = (w_cyc_nxt == CNT_W'(TIMEOUT + 1));
  assign w_last    = w_rel_mask[NUM_CH-1];

  // Channels whose release point has been reached on this step.
  // The ASSERT->RELEASE edge counts as step 1.
  always_comb begin
    w_rel_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(w_rel_nxt) >= HOLD_CYC + i * STAGGER) begin
        w_rel_mask[i] = 1'b1;
      end
    end
  end

  // Main FSM: sequences the releases, counts run cycles, and latches the
  // halt cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ASSERT;
      r_rel_cnt     <= '0;
      r_rst_out     <= '1;
      r_done        <= 1'b0;
      r_halt        <= 1'b0;
      r_err_seen    <= 1'b0;
      r_timeout     <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      case (r_state)
        ASSERT, RELEASE: begin
          // err is deliberately ignored until RUN.
          if (r_state == RELEASE || w_sync) begin
            r_rel_cnt <= w_rel_nxt;
            r_rst_out <= r_rst_out & ~w_rel_mask;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= RUN;
            end else begin
              r_state <= RELEASE;
            end
          end
        end
        RUN: begin
          r_cycle_count <= w_cyc_nxt;
          if (err || w_tmo) begin
            r_state    <= HALT;
            r_halt     <= 1'b1;
            r_err_seen <= err;
            r_timeout  <= w_tmo;
            if (HALT_RST != 0) begin
              r_rst_out <= '1;
            end
          end
        end
        HALT: begin
          // Only rst_n leaves HALT. All state is frozen until then.
          r_state <= HALT;
        end
        default: begin
          r_state <= ASSERT;
        end
      endcase
    end
  end

  assign rst_out     = r_rst_out;
  assign done        = r_done;
  assign halt        = r_halt;
  assign err_seen    = r_err_seen;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_count;
  assign o_dbg_state = r_state;

endmodule
